// File: rtl/dm_responder_if.sv
// dm_responder_if: load/store bus between the MEM stage (master) and the
// data-memory responder (slave).
//   Mem_r, Mem_w   : read / write request, held until Mem_ready
//   Mem_addr       : byte address (word aligned)
//   Mem_w_data     : store data
//   Mem_r_data     : load data, valid while Mem_ready=1, held otherwise
//   Mem_ready      : one-cycle completion pulse
//   Mem_stall      : combinational pipeline hold request
//   Mem_err        : completion carried a misaligned / out-of-range address
interface dm_responder_if;
  logic        Mem_r;
  logic        Mem_w;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_w_data;
  logic [31:0] Mem_r_data;
  logic        Mem_ready;
  logic        Mem_stall;
  logic        Mem_err;

  modport master (
    output Mem_r, Mem_w, Mem_addr, Mem_w_data,
    input  Mem_r_data, Mem_ready, Mem_stall, Mem_err
  );

  modport slave (
    input  Mem_r, Mem_w, Mem_addr, Mem_w_data,
    output Mem_r_data, Mem_ready, Mem_stall, Mem_err
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: configurable-latency word memory answering the pipeline's
// load/store requests with a ready/stall handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : dm_responder_if.slave, request in / response + stall out
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, word index = Mem_addr[31:2]
//   LATENCY     : cycles from acceptance to Mem_ready, 1..15
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no access outstanding; a request here is accepted
// S_WAIT | access accepted, counting down the remaining latency
// S_RESP | Mem_ready pulse; write commits on the edge leaving here
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input logic            clk,
  input logic            rst,
  dm_responder_if.slave  bus
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT is entered with LATENCY-2 so that the RESP cycle lands at t+LATENCY.
  localparam logic [3:0] WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            in_err;
  logic [IW-1:0]   in_idx;

  // A simultaneous read+write is a write that also returns the old word.
  assign req    = bus.Mem_r | bus.Mem_w;
  assign in_err = (bus.Mem_addr[1:0] != 2'b00) ||
                  ({2'b00, bus.Mem_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign in_idx = bus.Mem_addr[IW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = in_idx;
          wdata_d = bus.Mem_w_data;
          wr_d    = bus.Mem_w;
          err_d   = in_err;
          if (LATENCY <= 1) begin
            state_d = S_RESP;
            rdata_d = in_err ? 32'd0 : mem[in_idx];
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          // Read data is captured on entry to RESP so it is registered while
          // Mem_ready is high; a write sees the old word here.
          rdata_d = err_q ? 32'd0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; a reset coinciding with the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.Mem_r_data = rdata_q;
  assign bus.Mem_ready  = (state_q == S_RESP);
  assign bus.Mem_err    = (state_q == S_RESP) && err_q;
  assign bus.Mem_stall  = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_responder_if if0 ();
  dm_responder_if if1 ();

  dm_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  dm_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] mdl [2][64];
  time         t_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.Mem_r = r; if0.Mem_w = w; if0.Mem_addr = a; if0.Mem_w_data = wd;
    end else begin
      if1.Mem_r = r; if1.Mem_w = w; if1.Mem_addr = a; if1.Mem_w_data = wd;
    end
  endtask

  function automatic logic f_ready(input int d);
    return (d == 0) ? if0.Mem_ready : if1.Mem_ready;
  endfunction
  function automatic logic f_stall(input int d);
    return (d == 0) ? if0.Mem_stall : if1.Mem_stall;
  endfunction
  function automatic logic f_err(input int d);
    return (d == 0) ? if0.Mem_err : if1.Mem_err;
  endfunction
  function automatic logic [31:0] f_rdata(input int d);
    return (d == 0) ? if0.Mem_r_data : if1.Mem_r_data;
  endfunction

  // One access on DUT d; returns at the falling edge inside the Mem_ready cycle.
  task automatic access(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit scramble, input string tag);
    int          lat;
    int          n;
    logic        exp_err;
    logic [5:0]  idx;
    logic [31:0] exp_rd;
    lat     = (d == 0) ? 2 : 1;
    exp_err = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    idx     = a[7:2];
    exp_rd  = exp_err ? 32'd0 : mdl[d][idx];
    @(posedge clk); #1;
    drive(d, r, w, a, wd);
    @(negedge clk);
    chk({tag, "/stall_req"}, 32'(f_stall(d)), 32'd1);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      if (n == 0 && scramble) drive(d, r, w, a ^ 32'h4, ~wd);
      @(negedge clk);
      n++;
      if (f_ready(d)) break;
      chk({tag, "/stall_wait"}, 32'(f_stall(d)), 32'd1);
    end
    t_ready = $time;
    chk({tag, "/latency"}, 32'(n), 32'(lat));
    chk({tag, "/ready"}, 32'(f_ready(d)), 32'd1);
    chk({tag, "/stall_resp"}, 32'(f_stall(d)), 32'd0);
    chk({tag, "/err"}, 32'(f_err(d)), 32'(exp_err));
    if (r || exp_err) chk({tag, "/rdata"}, f_rdata(d), exp_rd);
    if (w && !exp_err) mdl[d][idx] = wd;
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    time t_first;
    int  seen;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst/ready", 32'(f_ready(d)), 32'd0);
      chk("rst/err",   32'(f_err(d)),   32'd0);
      chk("rst/rdata", f_rdata(d),      32'd0);
      chk("rst/stall", 32'(f_stall(d)), 32'd0);
    end

    // Give every word a known value so later reads have a defined model.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        access(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, "init");

    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "t1_wr");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "t1_rd");
    chk("t1/data", f_rdata(0), 32'hDEADBEEF);

    access(0, 1'b0, 1'b1, 32'h0, 32'h11, 1'b0, "t2_wr0");
    access(0, 1'b0, 1'b1, 32'h4, 32'h22, 1'b0, "t2_wr1");
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "t2_rd0");
    chk("t2/data0", f_rdata(0), 32'h11);
    t_first = t_ready;
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "t2_rd1");
    chk("t2/data1", f_rdata(0), 32'h22);
    chk("t2/spacing", 32'(t_ready - t_first), 32'd30);

    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, "t3_misal");
    chk("t3/misal_data", f_rdata(0), 32'h0);
    access(0, 1'b0, 1'b1, 32'h100, 32'h999, 1'b0, "t3_oor");
    chk("t3/oor_err", 32'(f_err(0)), 32'd1);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "t3_rd0");
    chk("t3/no_alias", f_rdata(0), 32'h11);

    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h8, 32'hCAFE0000);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (f_ready(0)) seen++;
    end
    chk("t4/no_ready", 32'(seen), 32'd0);
    chk("t4/idle_stall", 32'(f_stall(0)), 32'd0);
    chk("t4/rdata_rst", f_rdata(0), 32'd0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "t4_rd");

    access(0, 1'b1, 1'b1, 32'h4, 32'h55, 1'b0, "t5_rw");
    chk("t5/old_word", f_rdata(0), 32'h22);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "t5_rd");
    chk("t5/new_word", f_rdata(0), 32'h55);

    access(1, 1'b0, 1'b1, 32'h4, 32'h22, 1'b0, "t6_wr");
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, "t6_rd");
    chk("t6/data", f_rdata(1), 32'h22);

    for (int i = 0; i < 80; i++) begin
      int          d;
      int          kind;
      int          op;
      logic [31:0] a;
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 7);
      op   = $urandom_range(0, 2);
      if (kind < 6)       a = 32'($urandom_range(0, 63)) << 2;
      else if (kind == 6) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else                a = 32'($urandom_range(64, 4000)) << 2;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      access(d, op != 1, op != 0, a, $urandom, 1'b0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the pipeline's load/store interface (Mem_r / Mem_w / Mem_addr / Mem_w_data -> Mem_r_data).
- Replaces the single-cycle data memory model with a configurable-latency word memory.
- Adds a ready/stall handshake so the MEM stage can freeze the pipeline while an access is outstanding.
- Sits between EX_MEM and MEM_WB; its Mem_stall output feeds the pipeline's write-enable and hold logic.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; word index = Mem_addr[31:2].
- LATENCY, 2, cycles from request acceptance to Mem_ready; legal range is 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Mem_r  input  1  read request (load in the MEM stage).
- Mem_w  input  1  write request (store in the MEM stage).
- Mem_addr  input  32  byte address; must be word-aligned.
- Mem_w_data  input  32  store data.
- Mem_r_data  output  32  load data; registered; valid in the cycle Mem_ready=1.
- Mem_ready  output  1  one-cycle pulse marking completion of the accepted request.
- Mem_stall  output  1  combinational; the pipeline must hold PC, IF_ID, ID_EX and EX_MEM while this is 1.
- Mem_err  output  1  pulses with Mem_ready when the completed request was misaligned or out of range.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst=1 at an edge): state=IDLE, counter=0, Mem_r_data=0, Mem_ready=0, Mem_err=0.
  - Memory array contents are not changed by reset.
  - Reset mid-operation aborts the request; a pending write is dropped and never committed.
- Request present = Mem_r | Mem_w. If both are high, the request is treated as a write (a write also returns the old word on Mem_r_data).
- IDLE, request present at edge t:
  - Capture addr, data, rd/wr and the error flag: err = Mem_addr[1:0]!=0 or Mem_addr[31:2]>=DEPTH_WORDS.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
- IDLE, no request: stay in IDLE. Mem_stall=0.
- WAIT: if counter==0, go to RESP; otherwise decrement counter.
- RESP (one cycle):
  - Mem_ready=1 and Mem_err=err.
  - If not err: read returns mem[idx]; write commits mem[idx] at the RESP->IDLE edge.
  - If err: no array access, and Mem_r_data=0.
  - Always return to IDLE next cycle.
- Latency: request accepted at edge t -> Mem_ready high in cycle t+LATENCY.
- Mem_stall = (state==IDLE & request present) | (state==WAIT). It is 0 in RESP, so the pipeline advances on the same edge that ends RESP.
- Requester rule: Mem_r, Mem_w, Mem_addr and Mem_w_data are held stable from acceptance until Mem_ready. Changes after acceptance are ignored because inputs are latched at acceptance.
- A request present in the cycle after RESP is a new request, accepted from IDLE. Back-to-back throughput is one access per LATENCY+1 cycles.
- Mem_r_data holds its last value between responses. Only a RESP cycle or rst changes it.
- Memory is single-port, so at most one access is outstanding.
- Word index wrap is not allowed: out-of-range accesses are flagged, never aliased.

Test Plan:
1. LATENCY=2, reset, then write addr 0x10 data 0xDEADBEEF -> Mem_stall=1 for 2 cycles, Mem_ready pulses at t+2, Mem_err=0. Then read 0x10 -> Mem_r_data=0xDEADBEEF at t+2.
2. Back-to-back: reads of 0x0 then 0x4 (each previously written 0x11, 0x22) -> two Mem_ready pulses 3 cycles apart with data 0x11 then 0x22. Mem_stall=0 exactly in each RESP cycle.
3. Misaligned read of 0x13 and out-of-range write of 0x100 (DEPTH_WORDS=64):
   - Read -> Mem_ready with Mem_err=1, Mem_r_data=0.
   - Write -> Mem_ready with Mem_err=1; a subsequent read of 0x0 still returns 0x11 (no alias write).
4. Reset mid-operation: write 0x8=0xCAFE0000, assert rst in WAIT -> no Mem_ready, state IDLE. A later read of 0x8 returns the pre-write value.
5. Mem_r and Mem_w both high, addr 0x4 (holds 0x22), data 0x55 -> Mem_r_data=0x22 at Mem_ready; a next read returns 0x55.
6. LATENCY=1 build: read 0x4 -> Mem_ready in the cycle after acceptance, Mem_stall=1 for exactly 1 cycle. Changing Mem_addr after acceptance does not alter the returned data.
